// File: rtl/star_power_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : star_power_ctrl
// Brief    : Counts each star touch once per game and times the invincibility
//            window (POWER -> FLASH blink -> IDLE) in frame ticks.
//            Optional build macro STAR_POWER_STACK_EN: collects during an
//            active window add POWER_TICKS instead of reloading.
// Revision : 1.0 - initial release
// ============================================================================
module star_power_ctrl #(
    parameter int NUM_STARS    = 4,
    parameter int POWER_TICKS  = 300,
    parameter int FLASH_TICKS  = 60,
    parameter int BLINK_PERIOD = 4
) (
    input  logic                 sys_clk,
    input  logic                 RST_N,
    input  logic [NUM_STARS-1:0] touch_star,
    input  logic                 frame_tick,
    input  logic                 game_reset,
    output logic [3:0]           star_count,
    output logic                 all_collected,
    output logic                 collect_pulse,
    output logic                 invincible,
    output logic                 blink,
    output logic [9:0]           power_remaining
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_power = 2'd1;
    localparam logic [1:0] c_st_flash = 2'd2;

    localparam logic [9:0] c_power_ticks = 10'(POWER_TICKS);
    localparam logic [9:0] c_flash_ticks = 10'(FLASH_TICKS);
    localparam int         c_bcnt_w      = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [c_bcnt_w-1:0] c_blink_last = c_bcnt_w'(BLINK_PERIOD - 1);

    logic [1:0]           state_q,     state_d;
    logic [NUM_STARS-1:0] touch_q,     touch_d;
    logic [NUM_STARS-1:0] collected_q, collected_d;
    logic [3:0]           star_count_q, star_count_d;
    logic                 all_q,       all_d;
    logic                 pulse_q,     pulse_d;
    logic                 blink_q,     blink_d;
    logic [c_bcnt_w-1:0]  bcnt_q,      bcnt_d;
    logic [9:0]           power_q,     power_d;

    logic [NUM_STARS-1:0] new_stars;
    logic                 collect_ev;
    logic [3:0]           new_cnt;
    logic [4:0]           count_sum;
    logic [3:0]           count_sat;
    logic [9:0]           power_dec;

`ifdef STAR_POWER_STACK_EN
    logic [10:0]          stack_sum;
    logic [9:0]           stack_sat;
    assign stack_sum = {1'b0, power_q} + {1'b0, c_power_ticks};
    assign stack_sat = stack_sum[10] ? 10'h3FF : stack_sum[9:0];
`endif

    // Rising edge on a star not yet collected this game
    assign new_stars  = touch_star & ~touch_q & ~collected_q;
    assign collect_ev = |new_stars;
    assign power_dec  = (power_q != 10'd0) ? (power_q - 10'd1) : 10'd0;

    always_comb begin
        new_cnt = 4'd0;
        for (int i = 0; i < NUM_STARS; i++) begin
            new_cnt = new_cnt + {3'd0, new_stars[i]};
        end
    end

    assign count_sum = {1'b0, star_count_q} + {1'b0, new_cnt};
    assign count_sat = (count_sum > 5'd15) ? 4'hF : count_sum[3:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= c_st_idle;
            touch_q      <= '0;
            collected_q  <= '0;
            star_count_q <= 4'd0;
            all_q        <= 1'b0;
            pulse_q      <= 1'b0;
            blink_q      <= 1'b1;
            bcnt_q       <= '0;
            power_q      <= 10'd0;
        end else begin
            state_q      <= state_d;
            touch_q      <= touch_d;
            collected_q  <= collected_d;
            star_count_q <= star_count_d;
            all_q        <= all_d;
            pulse_q      <= pulse_d;
            blink_q      <= blink_d;
            bcnt_q       <= bcnt_d;
            power_q      <= power_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        touch_d      = touch_star;
        collected_d  = collected_q | new_stars;
        star_count_d = count_sat;
        all_d        = &(collected_q | new_stars);
        pulse_d      = collect_ev;
        state_d      = state_q;
        blink_d      = blink_q;
        bcnt_d       = bcnt_q;
        power_d      = power_q;

        if (game_reset) begin
            touch_d      = '0;
            collected_d  = '0;
            star_count_d = 4'd0;
            all_d        = 1'b0;
            pulse_d      = 1'b0;
            state_d      = c_st_idle;
            blink_d      = 1'b1;
            bcnt_d       = '0;
            power_d      = 10'd0;
        end else if (collect_ev) begin
            // A collect overrides any same-cycle frame tick
            state_d = c_st_power;
            blink_d = 1'b1;
            bcnt_d  = '0;
`ifdef STAR_POWER_STACK_EN
            power_d = (state_q == c_st_idle) ? c_power_ticks : stack_sat;
`else
            power_d = c_power_ticks;
`endif
        end else if (frame_tick) begin
            case (state_q)
                c_st_power: begin
                    power_d = power_dec;
                    if (power_dec == 10'd0) begin
                        state_d = c_st_idle;
                        blink_d = 1'b1;
                        bcnt_d  = '0;
                    end else if (power_dec <= c_flash_ticks) begin
                        state_d = c_st_flash;
                        blink_d = 1'b0;
                        bcnt_d  = '0;
                    end
                end
                c_st_flash: begin
                    power_d = power_dec;
                    if (power_dec == 10'd0) begin
                        state_d = c_st_idle;
                        blink_d = 1'b1;
                        bcnt_d  = '0;
                    end else if (bcnt_q == c_blink_last) begin
                        blink_d = ~blink_q;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d  = bcnt_q + c_bcnt_w'(1);
                    end
                end
                c_st_idle: begin
                    power_d = power_q;
                end
                default: begin
                    state_d = c_st_idle;
                    blink_d = 1'b1;
                    bcnt_d  = '0;
                    power_d = 10'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        star_count      = star_count_q;
        all_collected   = all_q;
        collect_pulse   = pulse_q;
        invincible      = (state_q != c_st_idle);
        blink           = blink_q;
        power_remaining = power_q;
    end

endmodule
`default_nettype wire

// File: doc/star_power_ctrl.md
Name: star_power_ctrl

Overview:
Consumer end of the star touch interface. Takes per-star touch indications from the star collectible blocks and counts each star at most once per game. Each new collection starts or refreshes an invincibility window that is timed in frame ticks and ends with a blink phase. Sits between the star blocks and the character renderer/score logic.

Parameters:
NUM_STARS, 4, number of star touch inputs (1..8)
POWER_TICKS, 300, invincibility length in frame ticks (1..1023)
FLASH_TICKS, 60, final ticks of the window spent blinking (< POWER_TICKS)
BLINK_PERIOD, 4, frame ticks per blink half-period (>= 1)

Ports:
sys_clk  input  1  system clock
RST_N  input  1  asynchronous active-low reset
touch_star  input  NUM_STARS  touch flag from each star block, level or pulse
frame_tick  input  1  one-cycle pulse per video frame
game_reset  input  1  synchronous clear for a new game
star_count  output  4  stars collected this game, saturating at 15
all_collected  output  1  high when every star has been collected
collect_pulse  output  1  one-cycle pulse on any new collection
invincible  output  1  high in POWER and FLASH states
blink  output  1  sprite visibility modulation (1 = visible)
power_remaining  output  10  remaining window in ticks

Behaviour:
- Reset is RST_N, asynchronous, active-low; clock is sys_clk. Reset values:
  - star_count = 0, collected mask = 0, all_collected = 0
  - collect_pulse = 0, invincible = 0, blink = 1, power_remaining = 0
  - state = IDLE, edge-detect registers = 0
- game_reset has the same effect as reset, applied synchronously. It has priority over every other event in the same cycle.
- Collection detection:
  - new[i] = touch_star[i] & ~touch_q[i] & ~collected[i], where touch_q is touch_star delayed by one cycle.
  - When any new bit is set, on the next edge: collected |= new; star_count += popcount(new), saturating at 15; collect_pulse = 1 for one cycle.
  - Outputs are registered, so latency is 1 cycle from the touch edge.
  - A held-high touch counts once. A re-touch of a star that is already collected is ignored.
- all_collected = (collected == all ones), registered.
- State machine:
  - IDLE: on a collect event, go to POWER with power_remaining = POWER_TICKS.
  - POWER: each frame_tick decrements power_remaining. When the decremented value is <= FLASH_TICKS, go to FLASH and reset the blink counter.
  - FLASH: each frame_tick decrements power_remaining. blink toggles every BLINK_PERIOD ticks and starts at 0 on FLASH entry. When the decremented value reaches 0, go to IDLE with blink = 1.
  - A collect event in POWER or FLASH reloads the window (see Optional Feature), returns to POWER and sets blink = 1.
- Simultaneous collect and frame_tick in the same cycle: collect wins and no decrement is applied that cycle.
- frame_tick in IDLE has no effect. power_remaining never underflows.
- blink = 1 outside FLASH. invincible = (state != IDLE).

Optional Feature:
STAR_POWER_STACK_EN
- Defined: a collect event in POWER or FLASH adds POWER_TICKS to power_remaining, saturating at 1023. If the result exceeds FLASH_TICKS the state is POWER.
- Undefined: a collect event in POWER or FLASH reloads power_remaining to exactly POWER_TICKS.
- IDLE behaviour is identical in both builds.

Test Plan:
All scenarios use POWER_TICKS = 20, FLASH_TICKS = 6, BLINK_PERIOD = 2, NUM_STARS = 4.
1. Reset release, no stimulus -> star_count = 0, invincible = 0, blink = 1, power_remaining = 0.
2. Raise touch_star[1] and hold it for 10 cycles -> exactly one collect_pulse one cycle later, star_count = 1, power_remaining = 20, invincible = 1.
3. After the collect, send 14 frame_ticks -> power_remaining = 6 and state is FLASH. Six more ticks -> blink pattern 0,1,1,0,0 with blink = 1 at idle, invincible = 0, power_remaining = 0.
4. Raise touch_star[0], touch_star[2] and touch_star[3] in the same cycle -> single collect_pulse, star_count goes 1 -> 4, all_collected = 1.
5. Collect in FLASH with power_remaining = 3:
   - macro undefined -> power_remaining = 20, state POWER.
   - STAR_POWER_STACK_EN defined -> power_remaining = 23.
   - Also: frame_tick in the same cycle as the collect -> no decrement.
6. game_reset mid-POWER while a new touch edge is present -> all outputs at reset values next cycle and the touch is not counted. Also: RST_N asserted asynchronously -> outputs clear before the next clock edge.
